// File: rtl/mf8_ram_bridge.sv
// mf8 data-RAM bridge: byte requests from the core sequenced onto one 16-bit SPRAM with nibble masks.
// Define MF8_RAMBR_POSTED_WR_EN to enable the one-entry posted-write buffer.
module mf8_ram_bridge #(
    parameter int unsigned WORDS       = 16384,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] zz,
    input  logic [7:0]  wdata,
    input  logic        ram_read,
    input  logic        ram_write,
    output logic [7:0]  ram_datain,
    output logic        ram_ready,
    output logic        err_ovr,
    output logic [13:0] sp_addr,
    output logic [15:0] sp_din,
    output logic [3:0]  sp_maskwe,
    output logic        sp_we,
    output logic        sp_cs,
    input  logic [15:0] sp_dout
);

    localparam logic [16:0] ByteLimit = 17'(2 * WORDS);
    localparam logic [2:0]  WaitLoad  = 3'((WAIT_STATES == 0) ? 0 : (WAIT_STATES - 1));

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StCapture,
        StWait,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [13:0] op_word_q, op_word_d;
    logic        op_lane_q, op_lane_d;
    logic [7:0]  op_data_q, op_data_d;
    logic        op_wr_q, op_wr_d;
    logic        op_rng_q, op_rng_d;
    logic [2:0]  wait_q, wait_d;
    logic [7:0]  rbyte_q, rbyte_d;
    logic [7:0]  datain_q, datain_d;
    logic        err_q, err_d;
`ifdef MF8_RAMBR_POSTED_WR_EN
    logic        buf_valid_q, buf_valid_d;
    logic        rd_pend_q, rd_pend_d;
    logic [15:0] rd_addr_q, rd_addr_d;
    logic        post_ack_q, post_ack_d;
`endif

    logic        req_any;
    logic        take;
    logic        take_wr;
    logic [15:0] take_addr;

    assign req_any = ram_read | ram_write;
    assign err_ovr = err_q;

    always_comb begin
        state_d   = state_q;
        op_word_d = op_word_q;
        op_lane_d = op_lane_q;
        op_data_d = op_data_q;
        op_wr_d   = op_wr_q;
        op_rng_d  = op_rng_q;
        wait_d    = wait_q;
        rbyte_d   = rbyte_q;
        datain_d  = datain_q;
        err_d     = err_q;
`ifdef MF8_RAMBR_POSTED_WR_EN
        buf_valid_d = buf_valid_q;
        rd_pend_d   = rd_pend_q;
        rd_addr_d   = rd_addr_q;
        post_ack_d  = 1'b0;
`endif
        take       = 1'b0;
        take_wr    = ram_write;
        take_addr  = zz;
        sp_cs      = 1'b0;
        sp_we      = 1'b0;
        sp_addr    = '0;
        sp_din     = '0;
        sp_maskwe  = '0;
        ram_ready  = 1'b0;
        ram_datain = datain_q;

        unique case (state_q)
            StIdle: begin
`ifdef MF8_RAMBR_POSTED_WR_EN
                // A read parked behind a drain launches before any new request.
                if (rd_pend_q) begin
                    take      = 1'b1;
                    take_wr   = 1'b0;
                    take_addr = rd_addr_q;
                    rd_pend_d = 1'b0;
                    if (req_any) err_d = 1'b1;
                end else if (req_any) begin
                    take = 1'b1;
                    if (ram_write) begin
                        buf_valid_d = 1'b1;
                        post_ack_d  = 1'b1;
                    end
                    if (ram_read && ram_write) err_d = 1'b1;
                end
`else
                if (req_any) begin
                    take = 1'b1;
                    if (ram_read && ram_write) err_d = 1'b1;
                end
`endif
            end
            StAccess: begin
                if (op_rng_q) begin
                    sp_cs   = 1'b1;
                    sp_addr = op_word_q;
                    if (op_wr_q) begin
                        sp_we     = 1'b1;
                        sp_din    = {op_data_q, op_data_q};
                        sp_maskwe = op_lane_q ? 4'b1100 : 4'b0011;
                    end
                end
                state_d = StCapture;
            end
            StCapture: begin
                if (!op_wr_q) begin
                    if (!op_rng_q)      rbyte_d = 8'h00;
                    else if (op_lane_q) rbyte_d = sp_dout[15:8];
                    else                rbyte_d = sp_dout[7:0];
                end
                wait_d  = WaitLoad;
                state_d = (WAIT_STATES == 0) ? StDone : StWait;
            end
            StWait: begin
                if (wait_q == 3'd0) state_d = StDone;
                else                wait_d  = wait_q - 3'd1;
            end
            StDone: begin
`ifdef MF8_RAMBR_POSTED_WR_EN
                // Drains were acknowledged when posted, so they finish silently.
                ram_ready   = !buf_valid_q;
                buf_valid_d = 1'b0;
`else
                ram_ready = 1'b1;
`endif
                if (!op_wr_q) begin
                    ram_datain = rbyte_q;
                    datain_d   = rbyte_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (take) begin
            state_d   = StAccess;
            op_word_d = take_addr[14:1];
            op_lane_d = take_addr[0];
            op_data_d = wdata;
            op_wr_d   = take_wr;
            op_rng_d  = ({1'b0, take_addr} < ByteLimit);
        end

        if (state_q != StIdle && req_any) begin
`ifdef MF8_RAMBR_POSTED_WR_EN
            if (ram_read && !ram_write && buf_valid_q && !rd_pend_q) begin
                rd_pend_d = 1'b1;
                rd_addr_d = zz;
            end else begin
                err_d = 1'b1;
            end
`else
            err_d = 1'b1;
`endif
        end

`ifdef MF8_RAMBR_POSTED_WR_EN
        if (post_ack_q) ram_ready = 1'b1;
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            op_word_q <= '0;
            op_lane_q <= 1'b0;
            op_data_q <= '0;
            op_wr_q   <= 1'b0;
            op_rng_q  <= 1'b0;
            wait_q    <= '0;
            rbyte_q   <= '0;
            datain_q  <= '0;
            err_q     <= 1'b0;
`ifdef MF8_RAMBR_POSTED_WR_EN
            buf_valid_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            post_ack_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_word_q <= op_word_d;
            op_lane_q <= op_lane_d;
            op_data_q <= op_data_d;
            op_wr_q   <= op_wr_d;
            op_rng_q  <= op_rng_d;
            wait_q    <= wait_d;
            rbyte_q   <= rbyte_d;
            datain_q  <= datain_d;
            err_q     <= err_d;
`ifdef MF8_RAMBR_POSTED_WR_EN
            buf_valid_q <= buf_valid_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
            post_ack_q  <= post_ack_d;
`endif
        end
    end

endmodule
